// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the program counter, presents it to
// the instruction memory, and captures the returned word into the IF/ID register.
// Supports hazard stalls, ID-stage redirects (the delay slot is kept), flushes,
// and tags fetches from misaligned or out-of-window addresses as faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              flush,
  input  logic [DATA_W-1:0] flush_pc,
  output logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr_i,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_pc8,
  output logic              id_valid,
  output logic              id_fault,
  output logic [DATA_W-1:0] fetch_count
);

  // Size of the legal fetch window in bytes, starting at RESET_PC.
  localparam logic [DATA_W-1:0] WIN_BYTES = DATA_W'(IM_WORDS * 4);

  // An address faults when misaligned or outside [RESET_PC, RESET_PC+WIN_BYTES).
  // The subtraction wraps, so addresses below RESET_PC become huge and fault too.
  function automatic logic fetch_fault(input logic [DATA_W-1:0] addr);
    logic [DATA_W-1:0] off;
    off = addr - RESET_PC;
    return (addr[1:0] != 2'b00) || (off >= WIN_BYTES);
  endfunction

  // Sequential-address arithmetic, modulo 2^DATA_W with no overflow indication.
  function automatic logic [DATA_W-1:0] pc_add(input logic [DATA_W-1:0] addr,
                                               input logic [DATA_W-1:0] inc);
    return addr + inc;
  endfunction

  logic              fault_p0;
  logic [DATA_W-1:0] pc_plus4_p0;
  logic [DATA_W-1:0] pc_plus8_p0;
  logic [DATA_W-1:0] instr_p0;
  logic              advance_p0;

  // ---- Stage p0: fetch at pc, combinational memory return ----
  // Fault check and sequential addresses derived from the current pc.
  always_comb begin
    fault_p0    = fetch_fault(pc);
    pc_plus4_p0 = pc_add(pc, DATA_W'(4));
    pc_plus8_p0 = pc_add(pc, DATA_W'(8));
    instr_p0    = fault_p0 ? '0 : instr_i;
    advance_p0  = !flush && !stall;
  end

  // Program counter: flush restart beats stall, which beats redirect / pc+4.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= flush_pc;
    end else if (!stall) begin
      pc <= redirect_valid ? redirect_pc : pc_plus4_p0;
    end
  end

  // ---- Stage p1: IF/ID register ----
  // IF/ID capture; a flush leaves a bubble, a stall holds the current entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_instr <= '0;
      id_pc    <= '0;
      id_pc8   <= '0;
      id_valid <= 1'b0;
      id_fault <= 1'b0;
    end else if (flush) begin
      id_instr <= '0;
      id_pc    <= '0;
      id_pc8   <= '0;
      id_valid <= 1'b0;
      id_fault <= 1'b0;
    end else if (!stall) begin
      id_instr <= instr_p0;
      id_pc    <= pc;
      id_pc8   <= pc_plus8_p0;
      id_valid <= 1'b1;
      id_fault <= fault_p0;
    end
  end

  // Count of fetches accepted into IF/ID; wraps naturally at 2^DATA_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (advance_p0) begin
      fetch_count <= pc_add(fetch_count, DATA_W'(1));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] pc;
  logic [31:0] instr_i;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        id_fault;
  logic [31:0] fetch_count;

  int n_vec;
  int n_miss;

  fetch_unit #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .flush_pc(flush_pc),
    .pc(pc),
    .instr_i(instr_i),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_pc8(id_pc8),
    .id_valid(id_valid),
    .id_fault(id_fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, otherwise C0DE in the upper half
  // and the low address half below, so every fetched word is recognisable.
  always_comb begin
    case (pc)
      32'h0000_3000: instr_i = 32'h3C01_0001;
      32'h0000_3004: instr_i = 32'h3421_0002;
      default:       instr_i = {16'hC0DE, pc[15:0]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic e_valid, input logic e_fault);
    chk({tag, ".id_instr"}, id_instr, e_instr);
    chk({tag, ".id_pc"}, id_pc, e_pc);
    chk({tag, ".id_pc8"}, id_pc8, e_valid ? e_pc + 32'd8 : 32'h0);
    chk({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, e_valid});
    chk({tag, ".id_fault"}, {31'h0, id_fault}, {31'h0, e_fault});
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    flush = 1'b0;
    flush_pc = 32'h0;

    // Power-on reset, held across two edges, released mid-cycle.
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst.pc", pc, 32'h3000);
    chk_id("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst.count", fetch_count, 32'h0);

    // Three free-running fetches.
    step();
    chk("free1.pc", pc, 32'h3004);
    chk_id("free1", 32'h3C01_0001, 32'h3000, 1'b1, 1'b0);
    step();
    chk("free2.pc", pc, 32'h3008);
    chk_id("free2", 32'h3421_0002, 32'h3004, 1'b1, 1'b0);
    chk("free2.pc8", id_pc8, 32'h300C);
    step();
    chk("free3.pc", pc, 32'h300C);
    chk("free3.count", fetch_count, 32'h3);

    // Asynchronous reset between edges, held over an edge, then restart.
    #2 reset = 1'b0;
    #1;
    chk("arst.pc", pc, 32'h3000);
    chk_id("arst", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("arst.count", fetch_count, 32'h0);
    step();
    chk("arst_hold.pc", pc, 32'h3000);
    #2 reset = 1'b1;
    step();
    chk("restart.pc", pc, 32'h3004);
    chk_id("restart", 32'h3C01_0001, 32'h3000, 1'b1, 1'b0);
    chk("restart.count", fetch_count, 32'h1);
    step();
    chk("restart2.pc", pc, 32'h3008);

    // Two-cycle stall at 0x3008 with a redirect held throughout.
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    step();
    step();
    chk("stall.pc", pc, 32'h3008);
    chk_id("stall", 32'h3421_0002, 32'h3004, 1'b1, 1'b0);
    chk("stall.count", fetch_count, 32'h2);
    stall = 1'b0;
    step();
    chk("unstall.pc", pc, 32'h3100);
    chk_id("unstall", 32'hC0DE_3008, 32'h3008, 1'b1, 1'b0);
    chk("unstall.count", fetch_count, 32'h3);
    redirect_valid = 1'b0;
    step();
    chk("tgt.pc", pc, 32'h3104);
    chk_id("tgt", 32'hC0DE_3100, 32'h3100, 1'b1, 1'b0);

    // Redirect at pc=0x3010 to 0x3100; delay slot at 0x3010 is kept.
    redirect_valid = 1'b1;
    redirect_pc = 32'h3010;
    step();
    chk("rd0.pc", pc, 32'h3010);
    redirect_pc = 32'h3100;
    step();
    chk_id("rd_slot", 32'hC0DE_3010, 32'h3010, 1'b1, 1'b0);
    chk("rd_slot.pc", pc, 32'h3100);
    redirect_valid = 1'b0;
    step();
    chk_id("rd_tgt", 32'hC0DE_3100, 32'h3100, 1'b1, 1'b0);
    step();
    chk_id("rd_tgt4", 32'hC0DE_3104, 32'h3104, 1'b1, 1'b0);
    chk("rd.count", fetch_count, 32'h8);

    // Flush together with stall and redirect: flush wins.
    flush = 1'b1;
    flush_pc = 32'h4180;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h5000;
    step();
    chk("flush.pc", pc, 32'h4180);
    chk_id("flush", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush.count", fetch_count, 32'h8);
    flush = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    // 0x4180 lies inside [0x3000, 0x7000), so this fetch is legal.
    chk_id("post_flush", 32'hC0DE_4180, 32'h4180, 1'b1, 1'b0);
    chk("post_flush.pc", pc, 32'h4184);
    chk("post_flush.count", fetch_count, 32'h9);

    // Window upper boundary: 0x6FFC is the last legal word, 0x7000 faults.
    flush = 1'b1;
    flush_pc = 32'h6FFC;
    step();
    flush = 1'b0;
    step();
    chk_id("win_last", 32'hC0DE_6FFC, 32'h6FFC, 1'b1, 1'b0);
    step();
    chk_id("win_end", 32'h0, 32'h7000, 1'b1, 1'b1);
    chk("win_end.count", fetch_count, 32'd11);

    // Redirect to a misaligned target: it and its successor both fault.
    redirect_valid = 1'b1;
    redirect_pc = 32'h3002;
    step();
    chk("mis.pc", pc, 32'h3002);
    redirect_valid = 1'b0;
    step();
    chk_id("mis0", 32'h0, 32'h3002, 1'b1, 1'b1);
    chk("mis0.pc", pc, 32'h3006);
    step();
    chk_id("mis1", 32'h0, 32'h3006, 1'b1, 1'b1);

    // Address wrap: 0xFFFFFFFC faults, pc+8 wraps to 4, then 0 faults (below base).
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    step();
    chk_id("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1);
    chk("wrap.pc8", id_pc8, 32'h4);
    chk("wrap.pc", pc, 32'h0);
    step();
    chk_id("below", 32'h0, 32'h0, 1'b1, 1'b1);
    chk("below.count", fetch_count, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
